// File: rtl/carryin_bin.sv
// Recovers the carry into every bit position of a binary sum from its two
// addends and the result: carry[i] = a[i] ^ b[i] ^ sum[i].
module carryin_bin #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_sum,
    output logic [WIDTH-1:0] o_carryin
);

    assign o_carryin = i_a ^ i_b ^ i_sum;

endmodule

// File: rtl/adder_subtractor_chunked_bin.sv
// Multi-cycle adder/subtractor: CHUNK_WIDTH bits per cycle with a registered
// inter-chunk carry, behind a valid/ready handshake on both sides.
module adder_subtractor_chunked_bin #(
    parameter int WORD_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic                  add_sub,
    input  logic                  carry_in,
    input  logic [WORD_WIDTH-1:0] A,
    input  logic [WORD_WIDTH-1:0] B,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic [WORD_WIDTH-1:0] carryin,
    output logic                  overflow
);

    localparam int CHUNK_COUNT = WORD_WIDTH / ((CHUNK_WIDTH >= 1) ? CHUNK_WIDTH : 1);
    localparam int CNT_W       = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNK_COUNT - 1);

    generate
        if (CHUNK_WIDTH < 1 || (WORD_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
            $error("CHUNK_WIDTH must be >= 1 and divide WORD_WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                                   r_state;
    state_t                                   w_next_state;
    logic [CNT_W-1:0]                         r_idx;
    logic                                     r_carry;
    logic                                     r_cout;
    logic [CHUNK_COUNT-1:0][CHUNK_WIDTH-1:0]  r_a;
    logic [CHUNK_COUNT-1:0][CHUNK_WIDTH-1:0]  r_b;
    logic [CHUNK_COUNT-1:0][CHUNK_WIDTH-1:0]  r_sum;
    logic [CHUNK_WIDTH:0]                     w_chunk;
    logic                                     w_last;
    logic [WORD_WIDTH-1:0]                    w_carryin;

    // One chunk per cycle; the MSB of w_chunk is the carry into the next chunk.
    assign w_chunk = {1'b0, r_a[r_idx]} + {1'b0, r_b[r_idx]}
                   + {{CHUNK_WIDTH{1'b0}}, r_carry};
    assign w_last  = (r_idx == LAST_IDX);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (input_valid)  w_next_state = ST_BUSY;
            ST_BUSY: if (w_last)       w_next_state = ST_DONE;
            ST_DONE: if (output_ready) w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (input_valid) begin
                        r_a     <= A;
                        r_b     <= add_sub ? ~B : B;
                        r_carry <= add_sub | carry_in;
                        r_idx   <= '0;
                    end
                end
                ST_BUSY: begin
                    r_sum[r_idx] <= w_chunk[CHUNK_WIDTH-1:0];
                    r_carry      <= w_chunk[CHUNK_WIDTH];
                    if (w_last) begin
                        r_cout <= w_chunk[CHUNK_WIDTH];
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    carryin_bin #(
        .WIDTH (WORD_WIDTH)
    ) u_carryin (
        .i_a       (r_a),
        .i_b       (r_b),
        .i_sum     (r_sum),
        .o_carryin (w_carryin)
    );

    // Handshake flags decode registered state only.
    assign input_ready  = (r_state == ST_IDLE);
    assign output_valid = (r_state == ST_DONE);
    assign sum          = r_sum;
    assign carry_out    = r_cout;
    assign carryin      = w_carryin;
    assign overflow     = r_cout ^ w_carryin[WORD_WIDTH-1];

endmodule
